// File: rtl/bcd_display_scan.sv
// bcd_display_scan: 4-digit multiplexed 7-segment scan driver.
// Snapshots dmin/umin/dseg/useg once per frame and scans them out.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   en           scan enable; low turns the display dark
//   dmin..useg   BCD digits 3..0 (dmin drives an[3], useg an[0])
//   colon_on     lights dp on digit 2 (sampled with the digits)
//   seg, dp, an  segment bus {g..a}, colon point, digit enables
//   frame_done   pulse on the last lit cycle of the digit-3 slot
//   err          snapshot held a non-BCD digit
module bcd_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZS          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] dmin,
  input  logic [3:0] umin,
  input  logic [3:0] dseg,
  input  logic [3:0] useg,
  input  logic       colon_on,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done,
  output logic       err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLNK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] BLNK_END  = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic          POL       = (ACTIVE_LOW != 0);
  localparam logic          LZS_EN    = (LZS != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            colon_q, colon_d;
  logic            err_q, err_d;

  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            fd_q, fd_d;

  logic            lit;
  logic [3:0]      an_h;
  logic [6:0]      seg_h;
  logic            dp_h;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h40;
    endcase
    return r;
  endfunction

  function automatic logic bad_bcd(input logic [3:0] v);
    return v > 4'd9;
  endfunction

  // Sequencer: slot counter spans the whole slot, blank part first.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    colon_d = colon_q;
    err_d   = err_q;
    if (!en) begin
      state_d = S_IDLE;
      slot_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end
        S_LOAD: begin
          dig_d   = {dmin, umin, dseg, useg};
          colon_d = colon_on;
          err_d   = bad_bcd(dmin) | bad_bcd(umin)
                  | bad_bcd(dseg) | bad_bcd(useg);
          slot_d  = 2'd0;
          cnt_d   = '0;
          state_d = S_BLANK;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLNK_LAST) begin
            cnt_d   = BLNK_END;
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (slot_q == 2'd3) begin
              state_d = S_LOAD;
            end else begin
              slot_d  = slot_q + 2'd1;
              state_d = S_BLANK;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are a registered image of the next state, so they line
  // up cycle-for-cycle with the state they describe.
  always_comb begin
    lit   = (state_d == S_SHOW)
          && !(LZS_EN && (slot_d == 2'd3) && (dig_q[3] == 4'd0));
    an_h  = 4'b0000;
    seg_h = 7'h00;
    dp_h  = 1'b0;
    if (lit) begin
      an_h  = 4'b0001 << slot_d;
      seg_h = dec7(dig_q[slot_d]);
      dp_h  = (slot_d == 2'd2) && colon_q;
    end
    an_d  = an_h ^ {4{POL}};
    seg_d = seg_h ^ {7{POL}};
    dp_d  = dp_h ^ POL;
    fd_d  = (state_d == S_SHOW) && (slot_d == 2'd3)
          && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
      dig_q   <= '0;
      colon_q <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= {7{POL}};
      dp_q    <= POL;
      an_q    <= {4{POL}};
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      colon_q <= colon_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed + random bench for bcd_display_scan.
// Two instances (LZS on/off) share stimulus; a frame-position model predicts outputs.
module tb_bcd_display_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] dmin, umin, dseg, useg;
  logic       colon_on;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic       fd_a, fd_b;
  logic       err_a, err_b;

  int checks = 0;
  int errors = 0;

  bcd_display_scan #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1), .LZS(1)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en),
    .dmin(dmin), .umin(umin), .dseg(dseg), .useg(useg),
    .colon_on(colon_on),
    .seg(seg_a), .dp(dp_a), .an(an_a),
    .frame_done(fd_a), .err(err_a)
  );

  bcd_display_scan #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1), .LZS(0)
  ) u_nolz (
    .clk(clk), .reset(reset), .en(en),
    .dmin(dmin), .umin(umin), .dseg(dseg), .useg(useg),
    .colon_on(colon_on),
    .seg(seg_b), .dp(dp_b), .an(an_b),
    .frame_done(fd_b), .err(err_b)
  );

  always #5 clk = ~clk;

  // Model: position within the frame, 0 = LOAD cycle.
  bit         m_idle;
  int         m_p;
  logic [3:0] m_snap [4];
  bit         m_colon;
  bit         m_err;

  function automatic logic [6:0] ref_dec(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (v > 4'd9) return 7'h40;
    return tbl[v];
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_p     = 0;
    m_colon = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (!en) begin
      m_idle = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_p    = 0;
    end else begin
      if (m_p == 0) begin
        m_snap[0] = useg;
        m_snap[1] = dseg;
        m_snap[2] = umin;
        m_snap[3] = dmin;
        m_colon   = colon_on;
        m_err     = (useg > 9) || (dseg > 9) || (umin > 9) || (dmin > 9);
      end
      m_p = (m_p == FR) ? 0 : m_p + 1;
    end
  endtask

  function automatic bit m_lit_slot(input int s);
    if (m_idle || m_p == 0) return 1'b0;
    return ((m_p - 1) / SD == s) && ((m_p - 1) % SD >= BC);
  endfunction

  // {an, seg, dp, frame_done} as seen on the active-low pins
  function automatic logic [12:0] exp_out(input bit lzs);
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    logic       f;
    int         sl, of;
    a = '0; s = '0; d = 1'b0; f = 1'b0;
    if (!m_idle && m_p != 0) begin
      sl = (m_p - 1) / SD;
      of = (m_p - 1) % SD;
      f  = (sl == 3) && (of == SD - 1);
      if (of >= BC && !(lzs && sl == 3 && m_snap[3] == 4'd0)) begin
        a[sl] = 1'b1;
        s     = ref_dec(m_snap[sl]);
        d     = (sl == 2) && m_colon;
      end
    end
    return {~a, ~s, ~d, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [12:0] ea, eb;
    ea = exp_out(1'b1);
    eb = exp_out(1'b0);
    chk("an",      32'(an_a),  32'(ea[12:9]));
    chk("seg",     32'(seg_a), 32'(ea[8:2]));
    chk("dp",      32'(dp_a),  32'(ea[1]));
    chk("fdone",   32'(fd_a),  32'(ea[0]));
    chk("err",     32'(err_a), 32'(m_err));
    chk("onehot",  32'($countones(~an_a) <= 1), 32'(1));
    chk("an_nolz", 32'(an_b),  32'(eb[12:9]));
    chk("seg_nolz",32'(seg_b), 32'(eb[8:2]));
    chk("dp_nolz", 32'(dp_b),  32'(eb[1]));
    chk("fd_nolz", 32'(fd_b),  32'(eb[0]));
    chk("err_nolz",32'(err_b), 32'(m_err));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step();
      check_all();
    end
  endtask

  task automatic wait_lit(input int s, input string tag);
    int g;
    g = 0;
    while (!m_lit_slot(s) && g < 80) begin
      cyc(1);
      g++;
    end
    chk(tag, 32'(g < 80), 32'(1));
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    int fdn;
    reset    = 1'b1;
    en       = 1'b1;
    dmin     = 4'd1;
    umin     = 4'd2;
    dseg     = 4'd3;
    useg     = 4'd4;
    colon_on = 1'b1;
    model_reset();

    #2;
    chk("rst_seg", 32'(seg_a), 32'(7'h7F));
    chk("rst_an",  32'(an_a),  32'(4'hF));
    chk("rst_dp",  32'(dp_a),  32'(1'b1));
    chk("rst_fd",  32'(fd_a),  32'(1'b0));
    chk("rst_err", 32'(err_a), 32'(1'b0));
    cyc(3);
    reset = 1'b0;

    // LOAD, two dark cycles, then digit 0 (useg=4) lit for 6 cycles
    cyc(1);
    chk("load_dark", 32'(an_a), 32'(4'hF));
    cyc(8);
    chk("d0_an",  32'(an_a),  32'(4'b1110));
    chk("d0_seg", 32'(seg_a), 32'(7'(~7'h66)));
    cyc(1);
    chk("gap_an", 32'(an_a), 32'(4'hF));
    cyc(2);
    chk("d1_an",  32'(an_a),  32'(4'b1101));
    chk("d1_seg", 32'(seg_a), 32'(7'(~7'h4F)));

    // useg changes mid-frame; new value only after the next LOAD
    useg = 4'd5;
    wait_lit(3, "wait_s3");
    wait_lit(0, "wait_s0");
    chk("new_useg", 32'(seg_a), 32'(7'(~7'h6D)));

    // frame_done period: exactly two pulses in 66 cycles
    fdn = 0;
    for (int i = 0; i < 2 * (FR + 1); i++) begin
      cyc(1);
      if (fd_a) fdn++;
    end
    chk("fd_count", 32'(fdn), 32'(2));

    // leading zero + colon
    dmin = 4'd0;
    colon_on = 1'b1;
    cyc(2 * (FR + 1));
    wait_lit(3, "wait_lz");
    chk("lz_an",    32'(an_a),  32'(4'hF));
    chk("lz_seg",   32'(seg_a), 32'(7'h7F));
    chk("nolz_an",  32'(an_b),  32'(4'b0111));
    chk("nolz_seg", 32'(seg_b), 32'(7'(~7'h3F)));

    // invalid digit then recovery
    umin = 4'hA;
    cyc(2 * (FR + 1));
    wait_lit(2, "wait_dash");
    chk("dash_seg", 32'(seg_a), 32'(7'(~7'h40)));
    chk("err_set",  32'(err_a), 32'(1'b1));
    umin = 4'd7;
    cyc(2 * (FR + 1));
    chk("err_clr", 32'(err_a), 32'(1'b0));

    // en dropped while slot 1 is lit
    wait_lit(1, "wait_en");
    en = 1'b0;
    cyc(1);
    chk("en_off_an", 32'(an_a), 32'(4'hF));
    cyc(3);
    en = 1'b1;
    cyc(BC + 2);
    wait_lit(0, "wait_restart");

    // asynchronous reset while lit
    wait_lit(2, "wait_rst");
    #1 reset = 1'b1;
    #1;
    chk("arst_an",  32'(an_a),  32'(4'hF));
    chk("arst_seg", 32'(seg_a), 32'(7'h7F));
    chk("arst_dp",  32'(dp_a),  32'(1'b1));
    chk("arst_err", 32'(err_a), 32'(1'b0));
    model_reset();
    cyc(2);
    reset = 1'b0;
    cyc(FR + 4);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) dmin = rnd_digit();
      if ($urandom_range(0, 19) == 0) umin = rnd_digit();
      if ($urandom_range(0, 19) == 0) dseg = rnd_digit();
      if ($urandom_range(0, 19) == 0) useg = rnd_digit();
      if ($urandom_range(0, 29) == 0) dmin = 4'd0;
      if ($urandom_range(0, 29) == 0) colon_on = ~colon_on;
      if ($urandom_range(0, 59) == 0) en = ~en;
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
